// File: rtl/accum_initiator.sv
// accum_initiator: second bus master that clears the accumulator peripheral,
// streams a job's words into its accumulate register, reads back sum and
// count, and reports the result with a one-cycle done pulse.
module accum_initiator #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] len,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] daddr,
  output logic [3:0]  dwe,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum_out,
  output logic [31:0] count_out,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_RD_SUM,
    S_RD_CNT,
    S_CAP
  } state_t;

  localparam logic [31:0] ADDR_CLEAR = BASE_ADDR;
  localparam logic [31:0] ADDR_ACC   = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_SUM   = BASE_ADDR + 32'd8;
  localparam logic [31:0] ADDR_CNT   = BASE_ADDR + 32'd12;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len_q;
  logic [15:0] r_rem;
  logic [31:0] r_sum;
  logic [31:0] r_count;
  logic        r_err;
  logic        r_done;
  logic        w_hs;

  assign w_hs = s_valid && (r_state == S_FEED);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and bus/stream outputs; the accumulate write is
  // combinational on the handshake so each word costs exactly one cycle.
  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    daddr   = '0;
    dwe     = '0;
    dwdata  = '0;
    busy    = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        daddr  = ADDR_CLEAR;
        dwe    = '1;
        w_next = (r_len_q == 16'd0) ? S_RD_SUM : S_FEED;
      end
      S_FEED: begin
        s_ready = 1'b1;
        if (w_hs) begin
          daddr  = ADDR_ACC;
          dwe    = '1;
          dwdata = s_data;
          if (r_rem == 16'd1) w_next = S_RD_SUM;
        end
      end
      S_RD_SUM: begin
        daddr  = ADDR_SUM;
        w_next = S_RD_CNT;
      end
      S_RD_CNT: begin
        daddr  = ADDR_CNT;
        w_next = S_CAP;
      end
      S_CAP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Job length, remaining-word counter, and result capture from readback.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_q <= '0;
      r_rem   <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE && start) begin
        r_len_q <= len;
        r_rem   <= len;
      end
      if (w_hs) r_rem <= r_rem - 16'd1;
      if (r_state == S_RD_CNT) r_sum <= drdata;
      if (r_state == S_CAP) begin
        r_count <= drdata;
        r_err   <= (drdata != {16'b0, r_len_q});
        r_done  <= 1'b1;
      end
    end
  end

  assign done      = r_done;
  assign sum_out   = r_sum;
  assign count_out = r_count;
  assign err       = r_err;

endmodule

// File: tb/tb_accum_initiator.sv
// Directed bench for accum_initiator with a behavioural accumulator
// peripheral on the bus.
module tb_accum_initiator;

  localparam logic [31:0] BASE = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] len;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] daddr;
  logic [3:0]  dwe;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        busy;
  logic        done;
  logic [31:0] sum_out;
  logic [31:0] count_out;
  logic        err;

  accum_initiator #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .daddr     (daddr),
    .dwe       (dwe),
    .dwdata    (dwdata),
    .drdata    (drdata),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .count_out (count_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Peripheral model: clear, accumulate, registered readback.
  logic [31:0] p_acc;
  logic [31:0] p_cnt;
  logic        force_en;
  logic [31:0] force_val;

  always @(posedge clk) begin
    if (reset) begin
      p_acc  <= '0;
      p_cnt  <= '0;
      drdata <= '0;
    end else begin
      if (dwe == 4'hF && daddr == BASE) begin
        p_acc <= '0;
        p_cnt <= '0;
      end else if (dwe == 4'hF && daddr == BASE + 32'd4) begin
        p_acc <= p_acc + dwdata;
        p_cnt <= p_cnt + 32'd1;
      end
      if (dwe == 4'h0 && daddr == BASE + 32'd8)       drdata <= p_acc;
      else if (dwe == 4'h0 && daddr == BASE + 32'd12) drdata <= force_en ? force_val : p_cnt;
      else                                            drdata <= '0;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;
  int hold;
  logic hs;
  logic [31:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle; inputs change at negedge, outputs sampled 1 time unit later.
  task automatic tick();
    @(negedge clk);
    cyc++;
    start = 1'b0;
    if (hs && q.size() > 0) void'(q.pop_front());
    if (hold > 0) begin
      s_valid = 1'b0;
      hold--;
    end else if (q.size() > 0) begin
      s_valid = 1'b1;
      s_data  = q[0];
    end else begin
      s_valid = 1'b0;
    end
    #1;
    hs = s_valid & s_ready;
  endtask

  task automatic begin_job(input logic [15:0] n);
    start = 1'b1;
    len   = n;
    cyc   = 0;
    hs    = 1'b0;
    hold  = 0;
    if (q.size() > 0) begin
      s_valid = 1'b1;
      s_data  = q[0];
    end else begin
      s_valid = 1'b0;
    end
    #1;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc, input logic [31:0] exp_sum,
                           input logic [31:0] exp_cnt, input logic exp_err);
    while (!done && cyc < 300) tick();
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_sum"}, sum_out, exp_sum);
    chk({tag, "_count"}, count_out, exp_cnt);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "_idle_at_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; len = 16'd9; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    force_en = 1'b0; force_val = '0; cyc = 0; hold = 0; hs = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sready", {31'b0, s_ready}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dwe", {28'b0, dwe}, 32'd0);
    chk("rst_dwdata", dwdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", sum_out, 32'd0);
    chk("rst_count", count_out, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    reset = 1'b0; start = 1'b0; s_valid = 1'b0;
    tick();

    // len=3, data 5,7,11 with s_valid constant high
    q = '{32'd5, 32'd7, 32'd11};
    begin_job(16'd3);
    chk("j1_c0_sready", {31'b0, s_ready}, 32'd0);
    tick();
    chk("j1_c1_daddr", daddr, BASE);
    chk("j1_c1_dwe", {28'b0, dwe}, 32'hF);
    chk("j1_c1_dwdata", dwdata, 32'd0);
    chk("j1_c1_sready", {31'b0, s_ready}, 32'd0);
    chk("j1_c1_busy", {31'b0, busy}, 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("j1_feed_sready", {31'b0, s_ready}, 32'd1);
      chk("j1_feed_daddr", daddr, BASE + 32'd4);
      chk("j1_feed_dwe", {28'b0, dwe}, 32'hF);
    end
    chk("j1_c4_dwdata", dwdata, 32'd11);
    tick();
    chk("j1_c5_daddr", daddr, BASE + 32'd8);
    chk("j1_c5_dwe", {28'b0, dwe}, 32'd0);
    chk("j1_c5_sready", {31'b0, s_ready}, 32'd0);
    tick();
    chk("j1_c6_daddr", daddr, BASE + 32'd12);
    tick();
    chk("j1_c7_daddr", daddr, 32'd0);
    chk("j1_c7_done", {31'b0, done}, 32'd0);
    wait_done("j1", 8, 32'd23, 32'd3, 1'b0);
    tick();
    chk("j1_done_width", {31'b0, done}, 32'd0);
    chk("j1_sum_hold", sum_out, 32'd23);

    // len=2 with a 3-cycle s_valid gap; sum wraps modulo 2^32
    q = '{32'hFFFF_FFFF, 32'd2};
    begin_job(16'd2);
    tick();
    tick();
    chk("j2_c2_dwdata", dwdata, 32'hFFFF_FFFF);
    hold = 3;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("j2_gap_sready", {31'b0, s_ready}, 32'd1);
      chk("j2_gap_dwe", {28'b0, dwe}, 32'd0);
      chk("j2_gap_daddr", daddr, 32'd0);
    end
    tick();
    chk("j2_c6_dwdata", dwdata, 32'd2);
    wait_done("j2", 10, 32'd1, 32'd2, 1'b0);
    tick();

    // len=0: clear then two reads
    q.delete();
    begin_job(16'd0);
    tick();
    chk("j0_c1_daddr", daddr, BASE);
    tick();
    chk("j0_c2_daddr", daddr, BASE + 32'd8);
    chk("j0_c2_sready", {31'b0, s_ready}, 32'd0);
    wait_done("j0", 5, 32'd0, 32'd0, 1'b0);
    tick();

    // start pulsed during FEED is ignored and not queued
    q = '{32'd1, 32'd2, 32'd3, 32'd4};
    begin_job(16'd4);
    tick(); tick(); tick();
    start = 1'b1; len = 16'd7;
    wait_done("jig", 9, 32'd10, 32'd4, 1'b0);
    tick();
    chk("jig_not_queued", {31'b0, busy}, 32'd0);

    // reset mid-FEED
    q = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500};
    begin_job(16'd5);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_sready", {31'b0, s_ready}, 32'd0);
    chk("mrst_daddr", daddr, 32'd0);
    chk("mrst_sum", sum_out, 32'd0);
    chk("mrst_count", count_out, 32'd0);
    reset = 1'b0;
    q.delete();
    tick();

    q = '{32'd9};
    begin_job(16'd1);
    wait_done("jpr", 6, 32'd9, 32'd1, 1'b0);
    tick();

    // forced count readback -> err; next job started in the done cycle clears it
    force_en = 1'b1; force_val = 32'd4;
    q = '{32'd1, 32'd1, 32'd1};
    begin_job(16'd3);
    wait_done("jerr", 8, 32'd3, 32'd4, 1'b1);
    force_en = 1'b0;
    q = '{32'd3, 32'd4};
    begin_job(16'd2);
    tick();
    chk("jok_accepted_busy", {31'b0, busy}, 32'd1);
    chk("jok_err_held", {31'b0, err}, 32'd1);
    wait_done("jok", 7, 32'd7, 32'd2, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
